// File: rtl/tune_pkg.sv
// Shared definitions for the melody sequencer: ROM word layout, FSM states,
// note codes matching the piano tone generator, and a default demo song.
package tune_pkg;

  localparam int ROM_W    = 16;
  localparam int LAST_BIT = 15;
  localparam int REST_BIT = 14;
  localparam int NOTE_HI  = 13;
  localparam int NOTE_LO  = 10;
  localparam int DUR_HI   = 9;
  localparam int DUR_W    = DUR_HI + 1;

  // Field order mirrors the bit positions above: [15] last, [14] rest, [13:10] note, [9:0] dur
  typedef struct packed {
    logic             last;
    logic             rest;
    logic [3:0]       note;
    logic [DUR_W-1:0] dur;
  } rom_word_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [3:0] NOTE_0 = 4'h0, NOTE_1 = 4'h1, NOTE_2 = 4'h2, NOTE_3 = 4'h3;
  localparam logic [3:0] NOTE_4 = 4'h4, NOTE_5 = 4'h5, NOTE_6 = 4'h6, NOTE_7 = 4'h7;
  localparam logic [3:0] NOTE_8 = 4'h8, NOTE_9 = 4'h9, NOTE_A = 4'hA, NOTE_B = 4'hB;
  localparam logic [3:0] NOTE_C = 4'hC, NOTE_D = 4'hD, NOTE_E = 4'hE, NOTE_F = 4'hF;

  localparam int DEMO_LEN = 32;

  function automatic logic [ROM_W-1:0] mk_word(input logic last, input logic rest,
                                               input logic [3:0] note,
                                               input logic [DUR_W-1:0] dur);
    return {last, rest, note, dur};
  endfunction

  // Rising eight-note figure repeated four times, quarter second per note
  function automatic logic [DEMO_LEN*ROM_W-1:0] demo_song();
    logic [DEMO_LEN*ROM_W-1:0] s;
    s = '0;
    for (int i = 0; i < DEMO_LEN; i++)
      s[i*ROM_W +: ROM_W] = mk_word(i == DEMO_LEN - 1, 1'b0, 4'(i % 8), 10'd250);
    return s;
  endfunction

endpackage

// File: rtl/tune_sequencer_if.sv
// Control/status bundle between a host and the melody sequencer.
interface tune_sequencer_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic             stop;
  logic             loop;
  logic [3:0]       note;
  logic             hush;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] index;

  modport master (output start, stop, loop, input note, hush, busy, done, index);
  modport slave  (input start, stop, loop, output note, hush, busy, done, index);
endinterface

// File: rtl/tune_rom.sv
// Song table, SONG_LEN x 16, synchronous read with one cycle of latency.
module tune_rom
  import tune_pkg::*;
#(
  parameter int                        SONG_LEN = 32,
  parameter int                        IDX_W    = 5,
  parameter logic [SONG_LEN*ROM_W-1:0] SONG     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] addr,
  output logic [ROM_W-1:0] word
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      word <= '0;
    else if (int'(addr) < SONG_LEN)
      word <= SONG[int'(addr)*ROM_W +: ROM_W];
    else
      word <= '0;
  end

endmodule

// File: rtl/tune_sequencer.sv
// Steps through the song ROM and drives note/hush of the piano tone generator,
// with a silent gap after each entry, loop-at-end and abort.
//
// state | meaning
// IDLE  | waiting for start; piano silenced
// FETCH | ROM read of entry at index in flight
// LOAD  | ROM word applied to note/hush, duration loaded
// PLAY  | entry sounding (or resting) until its duration expires
// GAP   | silent gap between entries
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int                        CLK_HZ    = 100_000_000,
  parameter int                        TICK_HZ   = 1000,
  parameter int                        SONG_LEN  = 32,
  parameter int                        GAP_TICKS = 20,
  parameter logic [SONG_LEN*ROM_W-1:0] SONG      = demo_song()
) (
  input logic             clk,
  input logic             reset,
  tune_sequencer_if.slave bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

  state_t           state;
  logic [PRE_W-1:0] pre_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] index;
  logic [3:0]       note;
  logic             hush;
  logic             done;
  logic             word_last;
  logic [ROM_W-1:0] rom_q;
  rom_word_t        word;
  logic             tick;
  logic             at_end;
  state_t           adv_state;
  logic [IDX_W-1:0] adv_index;
  logic             adv_done;

  tune_rom #(
    .SONG_LEN (SONG_LEN),
    .IDX_W    (IDX_W),
    .SONG     (SONG)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (index),
    .word  (rom_q)
  );

  assign word   = rom_word_t'(rom_q);
  // Prescaler only runs while timing an entry or gap, so each entry gets a full first tick
  assign tick   = (state == S_PLAY || state == S_GAP) && (pre_cnt == PRE_TC);
  assign at_end = word_last || (index == IDX_LAST);

  always_comb begin
    adv_state = S_FETCH;
    adv_index = index + 1'b1;
    adv_done  = 1'b0;
    if (at_end) begin
      adv_index = bus.loop ? '0 : index;
      if (!bus.loop) begin
        adv_state = S_IDLE;
        adv_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      index     <= '0;
      note      <= NOTE_0;
      hush      <= 1'b1;
      done      <= 1'b0;
      word_last <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_PLAY || state == S_GAP)
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      else
        pre_cnt <= '0;

      if (bus.stop) begin
        state   <= S_IDLE;
        pre_cnt <= '0;
        dur_cnt <= '0;
        gap_cnt <= '0;
        index   <= '0;
        hush    <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            // done is high in the cycle after a natural end; a start then is dropped
            if (bus.start && !done) begin
              state <= S_FETCH;
              index <= '0;
            end
          end
          S_FETCH: begin
            hush  <= 1'b1;
            state <= S_LOAD;
          end
          S_LOAD: begin
            note      <= word.note;
            hush      <= word.rest;
            dur_cnt   <= (word.dur == '0) ? DUR_W'(1) : word.dur;
            word_last <= word.last;
            state     <= S_PLAY;
          end
          S_PLAY: begin
            if (tick) begin
              if (dur_cnt == DUR_W'(1)) begin
                hush    <= 1'b1;
                dur_cnt <= '0;
                if (GAP_TICKS > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_W'(GAP_TICKS);
                end else begin
                  state <= adv_state;
                  index <= adv_index;
                  done  <= adv_done;
                end
              end else begin
                dur_cnt <= dur_cnt - 1'b1;
              end
            end
          end
          S_GAP: begin
            if (tick) begin
              if (gap_cnt == GAP_W'(1)) begin
                gap_cnt <= '0;
                state   <= adv_state;
                index   <= adv_index;
                done    <= adv_done;
              end else begin
                gap_cnt <= gap_cnt - 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.note  = note;
  assign bus.hush  = hush;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done;
  assign bus.index = index;

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: two instances (song with a last flag, song without),
// a cycle-timeline reference model feeding an event scoreboard.
module tb_tune_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int GAP     = 2;
  localparam int CPT     = CLK_HZ / TICK_HZ;

  function automatic logic [15:0] ent(input bit last, input bit rest, input int nt, input int dur);
    return {last, rest, 4'(nt), 10'(dur)};
  endfunction

  // entry 0 in the low word
  localparam logic [47:0] SONG_A = {ent(0, 0, 15, 4), ent(1, 0, 7, 1), ent(0, 0, 3, 2)};
  localparam logic [63:0] SONG_B = {ent(0, 0, 12, 2), ent(0, 0, 10, 0), ent(0, 1, 9, 3), ent(0, 0, 5, 1)};

  function automatic logic [15:0] song_word(input int d, input int i);
    if (d == 0) return SONG_A[i*16 +: 16];
    return SONG_B[i*16 +: 16];
  endfunction

  function automatic int song_len(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  typedef struct packed {
    logic [3:0] note;
    logic       hush;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } tup_t;

  typedef struct packed {
    int   cyc;
    tup_t tu;
  } ev_t;

  localparam tup_t RST_T = '{note: 4'h0, hush: 1'b1, busy: 1'b0, done: 1'b0, idx: 2'd0};
  localparam int PH_SETUP = 0, PH_SOUND = 1, PH_GAP = 2;

  logic clk;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, loop = 1'b0;

  tune_sequencer_if #(.IDX_W(2)) ifa ();
  tune_sequencer_if #(.IDX_W(2)) ifb ();

  assign ifa.start = start;
  assign ifa.stop  = stop;
  assign ifa.loop  = loop;
  assign ifb.start = start;
  assign ifb.stop  = stop;
  assign ifb.loop  = loop;

  tune_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SONG_LEN(3), .GAP_TICKS(GAP), .SONG(SONG_A)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  tune_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SONG_LEN(4), .GAP_TICKS(GAP), .SONG(SONG_B)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  ev_t  expq [2][$];
  tup_t m_prev [2];
  tup_t d_prev [2];

  // Reference model: the song as a timeline in clock cycles
  bit         m_act   [2];
  int         m_phase [2];
  int         m_left  [2];
  int         m_idx   [2];
  logic [3:0] m_note  [2];
  bit         m_hush  [2];
  bit         m_done  [2];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_entry(input int d);
    logic [15:0] w;
    w = song_word(d, m_idx[d]);
    if (w[15] || m_idx[d] == song_len(d) - 1) begin
      if (loop) begin
        m_idx[d] = 0; m_phase[d] = PH_SETUP; m_left[d] = 2;
      end else begin
        m_act[d] = 0; m_done[d] = 1;
      end
    end else begin
      m_idx[d]++; m_phase[d] = PH_SETUP; m_left[d] = 2;
    end
  endtask

  task automatic model_step(input int d);
    logic [15:0] w;
    bit was_done;
    if (reset) begin
      m_act[d] = 0; m_idx[d] = 0; m_note[d] = 4'h0; m_hush[d] = 1;
      m_done[d] = 0; m_left[d] = 0; m_phase[d] = PH_SETUP;
      return;
    end
    was_done  = m_done[d];
    m_done[d] = 0;
    if (stop) begin
      m_act[d] = 0; m_idx[d] = 0; m_hush[d] = 1;
    end else if (!m_act[d]) begin
      if (start && !was_done) begin
        m_act[d] = 1; m_idx[d] = 0; m_phase[d] = PH_SETUP; m_left[d] = 2;
      end
    end else begin
      m_left[d]--;
      if (m_left[d] == 0) begin
        case (m_phase[d])
          PH_SETUP: begin
            w = song_word(d, m_idx[d]);
            m_note[d]  = w[13:10];
            m_hush[d]  = w[14];
            m_phase[d] = PH_SOUND;
            m_left[d]  = CPT * ((w[9:0] == 10'd0) ? 1 : int'(w[9:0]));
          end
          PH_SOUND: begin
            m_hush[d] = 1;
            if (GAP > 0) begin
              m_phase[d] = PH_GAP; m_left[d] = CPT * GAP;
            end else begin
              next_entry(d);
            end
          end
          default: next_entry(d);
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      tup_t t;
      model_step(d);
      t = '{note: m_note[d], hush: m_hush[d], busy: m_act[d], done: m_done[d], idx: 2'(m_idx[d])};
      if (mon_en && t !== m_prev[d]) expq[d].push_back('{cyc: cyc, tu: t});
      m_prev[d] = t;
    end
  end

  function automatic tup_t dut_tup(input int d);
    if (d == 0) return '{note: ifa.note, hush: ifa.hush, busy: ifa.busy, done: ifa.done, idx: ifa.index};
    return '{note: ifb.note, hush: ifb.hush, busy: ifb.busy, done: ifb.done, idx: ifb.index};
  endfunction

  // Monitor: every change of the DUT outputs is one transaction
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        tup_t t;
        ev_t  e;
        while (expq[d].size() > 0 && expq[d][0].cyc < cyc) begin
          e = expq[d].pop_front();
          n_cmp++; n_bad++;
          $display("FAIL dut%0d missed_event: got no change, expected tuple %h at cyc %0d", d, e.tu, e.cyc);
        end
        t = dut_tup(d);
        if (t !== d_prev[d]) begin
          d_prev[d] = t;
          n_cmp++;
          if (expq[d].size() == 0) begin
            n_bad++;
            $display("FAIL dut%0d unexpected_change: got tuple %h at cyc %0d, expected no change", d, t, cyc);
          end else begin
            e = expq[d].pop_front();
            if (e.tu !== t || e.cyc != cyc) begin
              n_bad++;
              $display("FAIL dut%0d event: got tuple %h at cyc %0d, expected tuple %h at cyc %0d",
                       d, t, cyc, e.tu, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    d_prev[0] = RST_T;
    d_prev[1] = RST_T;
    mon_en    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // natural end on the last flag (A) and on SONG_LEN (B); start while busy
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    begin
      int k = 0;
      while (!ifa.done && k < 200) begin @(negedge clk); k++; end
      check("done_a_seen", int'(ifa.done), 1);
    end
    // start in the done cycle must be dropped
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("start_at_done_ignored", int'(ifa.busy), 0);
    repeat (120) @(negedge clk);
    check("b_idle_after_song", int'(ifb.busy), 0);
    check("b_index_at_end", int'(ifb.index), 3);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", int'(ifa.busy), 0);

    // looping, then abort
    loop = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (400) @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0; loop = 1'b0;
    check("stop_busy_b", int'(ifb.busy), 0);
    check("stop_hush_b", int'(ifb.hush), 1);
    check("stop_index_a", int'(ifa.index), 0);

    // reset mid-play silences immediately
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("playing_before_reset", int'(ifa.hush), 0);
    #1 reset = 1'b1;
    #1;
    check("reset_hush_a", int'(ifa.hush), 1);
    check("reset_hush_b", int'(ifb.hush), 1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_note", int'(ifa.note), 0);
    check("post_reset_busy", int'(ifa.busy), 0);
    check("post_reset_index", int'(ifa.index), 0);
    check("post_reset_done", int'(ifa.done), 0);

    // random control traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) loop = $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    repeat (250) @(negedge clk);
    @(negedge clk);
    check("pending_a", expq[0].size(), 0);
    check("pending_b", expq[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
